// File: rtl/sort_pkg.sv
// Shared types for the packet sorter: top-level FSM states and output-priming phases.
package sort_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        SORT,
        SEND
    } state_e;

    typedef enum logic [1:0] {
        PRIME_RD0,
        PRIME_LOAD,
        STREAM
    } send_phase_e;

endpackage

// File: rtl/sort_ram.sv
// Simple dual-port RAM: one write port, one read port with registered 1-cycle latency.
module sort_ram #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned AW     = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DWIDTH-1:0] rdata_o
);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sort.sv
// Packet sorter: collects one packet, bubble-sorts it in RAM, streams it out.
// Define SORT_DESCENDING_EN to sort in descending unsigned order instead of ascending.
module sort
    import sort_pkg::*;
#(
    parameter int unsigned DWIDTH      = 8,
    parameter int unsigned MAX_PKT_LEN = 1024
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    input  logic              src_ready_i,
    output logic              snk_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o
);

    localparam int unsigned AW = $clog2(MAX_PKT_LEN);
    localparam int unsigned CW = $clog2(MAX_PKT_LEN) + 1;
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] TWO      = CW'(2);
    localparam logic [CW-1:0] LAST_IDX = CW'(MAX_PKT_LEN - 1);

    state_e            state_q, state_d;
    send_phase_e       phase_q, phase_d;
    logic [CW-1:0]     wr_idx_q, wr_idx_d;
    logic [CW-1:0]     len_q, len_d;
    logic [CW-1:0]     pass_len_q, pass_len_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     out_idx_q, out_idx_d;
    logic [DWIDTH-1:0] carry_q, carry_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic [DWIDTH-1:0] data_q, data_d;

    logic              we;
    logic [AW-1:0]     waddr;
    logic [DWIDTH-1:0] wdata;
    logic [AW-1:0]     raddr;
    logic [DWIDTH-1:0] ram_rdata;
    logic              accept;
    logic              xfer;
    logic              keep_carry;

    sort_ram #(
        .DWIDTH (DWIDTH),
        .DEPTH  (MAX_PKT_LEN),
        .AW     (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (ram_rdata)
    );

    assign accept = snk_valid_i & ready_q;
    assign xfer   = valid_q & src_ready_i;

    // keep_carry: the carried word belongs later in the order, so the freshly read word is written back
`ifdef SORT_DESCENDING_EN
    assign keep_carry = carry_q < ram_rdata;
`else
    assign keep_carry = carry_q > ram_rdata;
`endif

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        wr_idx_d   = wr_idx_q;
        len_d      = len_q;
        pass_len_d = pass_len_q;
        cnt_d      = cnt_q;
        out_idx_d  = out_idx_q;
        carry_d    = carry_q;
        valid_d    = valid_q;
        sop_d      = sop_q;
        eop_d      = eop_q;
        data_d     = data_q;
        we         = 1'b0;
        waddr      = '0;
        wdata      = snk_data_i;
        raddr      = '0;

        case (state_q)
            IDLE, RECV: begin
                if (accept) begin
                    if (snk_startofpacket_i) begin
                        we       = 1'b1;
                        waddr    = '0;
                        wr_idx_d = ONE;
                        if (snk_endofpacket_i) begin
                            len_d   = ONE;
                            phase_d = PRIME_RD0;
                            state_d = SEND;
                        end else begin
                            state_d = RECV;
                        end
                    end else if (state_q == RECV) begin
                        we       = 1'b1;
                        waddr    = AW'(wr_idx_q);
                        wr_idx_d = wr_idx_q + ONE;
                        if (snk_endofpacket_i || wr_idx_q == LAST_IDX) begin
                            len_d      = wr_idx_q + ONE;
                            pass_len_d = wr_idx_q + ONE;
                            cnt_d      = '0;
                            state_d    = SORT;
                        end
                    end
                end
            end
            SORT: begin
                // Read data lags the address by one cycle: cnt==1 loads the carry,
                // cnt 2..L compare-and-write to cnt-2, cnt==L+1 writes the carry at the pass end.
                raddr = AW'(cnt_q);
                cnt_d = cnt_q + ONE;
                if (cnt_q == ONE) begin
                    carry_d = ram_rdata;
                end else if (cnt_q >= TWO && cnt_q <= pass_len_q) begin
                    we    = 1'b1;
                    waddr = AW'(cnt_q - TWO);
                    if (keep_carry) begin
                        wdata = ram_rdata;
                    end else begin
                        wdata   = carry_q;
                        carry_d = ram_rdata;
                    end
                end else if (cnt_q == pass_len_q + ONE) begin
                    we    = 1'b1;
                    waddr = AW'(pass_len_q - ONE);
                    wdata = carry_q;
                    cnt_d = '0;
                    if (pass_len_q == TWO) begin
                        phase_d = PRIME_RD0;
                        state_d = SEND;
                    end else begin
                        pass_len_d = pass_len_q - ONE;
                    end
                end
            end
            SEND: begin
                case (phase_q)
                    PRIME_RD0: begin
                        raddr   = '0;
                        phase_d = PRIME_LOAD;
                    end
                    PRIME_LOAD: begin
                        raddr     = AW'(ONE);
                        data_d    = ram_rdata;
                        valid_d   = 1'b1;
                        sop_d     = 1'b1;
                        eop_d     = (len_q == ONE);
                        out_idx_d = '0;
                        phase_d   = STREAM;
                    end
                    STREAM: begin
                        // Keep the RAM one word ahead of the output register so transfers run back-to-back.
                        raddr = AW'(xfer ? out_idx_q + TWO : out_idx_q + ONE);
                        if (xfer) begin
                            if (eop_q) begin
                                valid_d = 1'b0;
                                sop_d   = 1'b0;
                                eop_d   = 1'b0;
                                data_d  = '0;
                                phase_d = PRIME_RD0;
                                state_d = IDLE;
                            end else begin
                                out_idx_d = out_idx_q + ONE;
                                data_d    = ram_rdata;
                                sop_d     = 1'b0;
                                eop_d     = (out_idx_q + TWO == len_q);
                            end
                        end
                    end
                    default: phase_d = PRIME_RD0;
                endcase
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE) || (state_d == RECV);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q    <= IDLE;
            phase_q    <= PRIME_RD0;
            wr_idx_q   <= '0;
            len_q      <= '0;
            pass_len_q <= '0;
            cnt_q      <= '0;
            out_idx_q  <= '0;
            carry_q    <= '0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            wr_idx_q   <= wr_idx_d;
            len_q      <= len_d;
            pass_len_q <= pass_len_d;
            cnt_q      <= cnt_d;
            out_idx_q  <= out_idx_d;
            carry_q    <= carry_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            data_q     <= data_d;
        end
    end

    assign snk_ready_o         = ready_q;
    assign src_valid_o         = valid_q;
    assign src_startofpacket_o = sop_q;
    assign src_endofpacket_o   = eop_q;
    assign src_data_o          = data_q;

endmodule

// File: tb/tb_sort.sv
// Randomized self-checking bench for sort; expected output is the input packet sorted with queue sort().
module tb_sort;

    localparam int unsigned DW     = 8;
    localparam int unsigned MAXLEN = 64;

    logic          clk = 1'b0;
    logic          srst_i;
    logic [DW-1:0] snk_data_i;
    logic          snk_startofpacket_i;
    logic          snk_endofpacket_i;
    logic          snk_valid_i;
    logic          src_ready_i;
    logic          snk_ready_o;
    logic [DW-1:0] src_data_o;
    logic          src_startofpacket_o;
    logic          src_endofpacket_o;
    logic          src_valid_o;

    always #5 clk = ~clk;

    sort #(
        .DWIDTH      (DW),
        .MAX_PKT_LEN (MAXLEN)
    ) dut (
        .clk_i               (clk),
        .srst_i              (srst_i),
        .snk_data_i          (snk_data_i),
        .snk_startofpacket_i (snk_startofpacket_i),
        .snk_endofpacket_i   (snk_endofpacket_i),
        .snk_valid_i         (snk_valid_i),
        .src_ready_i         (src_ready_i),
        .snk_ready_o         (snk_ready_o),
        .src_data_o          (src_data_o),
        .src_startofpacket_o (src_startofpacket_o),
        .src_endofpacket_o   (src_endofpacket_o),
        .src_valid_o         (src_valid_o)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] pkt_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input int n);
        pkt_q.delete();
        for (int i = 0; i < n; i++) pkt_q.push_back(DW'($urandom));
    endtask

    task automatic send_pkt(input bit gaps, input bit use_eop);
        int i = 0;
        int cyc = 0;
        bit v;
        while (i < pkt_q.size() && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            v = !gaps || ($urandom_range(0, 2) != 0);
            snk_valid_i         = v;
            snk_data_i          = pkt_q[i];
            snk_startofpacket_i = (i == 0);
            snk_endofpacket_i   = use_eop && (i == pkt_q.size() - 1);
            if (v && snk_ready_o) i++;
        end
        check("send_accepted", i, pkt_q.size());
        @(negedge clk);
        snk_valid_i         = 1'b0;
        snk_startofpacket_i = 1'b0;
        snk_endofpacket_i   = 1'b0;
    endtask

    task automatic collect(input bit stall, input int n);
        int cyc = 0;
        int sop_bad = 0, eop_bad = 0, gap = 0, stall_bad = 0, rdy_bad = 0;
        bit started = 1'b0, prev_stall = 1'b0;
        logic [DW-1:0] pd;
        logic ps, pe;
        int k;
        got_q.delete();
        while (got_q.size() < n && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (prev_stall && (src_data_o !== pd || src_startofpacket_o !== ps || src_endofpacket_o !== pe))
                stall_bad++;
            if (started && !src_valid_o) gap++;
            if (snk_ready_o) rdy_bad++;
            src_ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (src_valid_o) started = 1'b1;
            prev_stall = src_valid_o && !src_ready_i;
            pd = src_data_o;
            ps = src_startofpacket_o;
            pe = src_endofpacket_o;
            if (src_valid_o && src_ready_i) begin
                k = got_q.size();
                if (src_startofpacket_o !== (k == 0)) sop_bad++;
                if (src_endofpacket_o !== (k == n - 1)) eop_bad++;
                got_q.push_back(src_data_o);
            end
        end
        check("out_len", got_q.size(), n);
        check("sop_marks", sop_bad, 0);
        check("eop_marks", eop_bad, 0);
        check("valid_gaps", gap, 0);
        check("stall_hold", stall_bad, 0);
        check("snk_ready_busy", rdy_bad, 0);
        @(negedge clk);
        check("exit_valid", src_valid_o, 0);
        check("exit_snk_ready", snk_ready_o, 1);
        src_ready_i = 1'b1;
    endtask

    task automatic run_pkt(input bit gaps, input bit stall, input bit use_eop);
        exp_q = pkt_q;
`ifdef SORT_DESCENDING_EN
        exp_q.rsort();
`else
        exp_q.sort();
`endif
        send_pkt(gaps, use_eop);
        collect(stall, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("word", got_q[i], exp_q[i]);
    endtask

    initial begin
        int vis;
        srst_i              = 1'b1;
        snk_data_i          = '0;
        snk_startofpacket_i = 1'b0;
        snk_endofpacket_i   = 1'b0;
        snk_valid_i         = 1'b0;
        src_ready_i         = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_snk_ready", snk_ready_o, 0);
        check("rst_valid", src_valid_o, 0);
        check("rst_sop", src_startofpacket_o, 0);
        check("rst_eop", src_endofpacket_o, 0);
        check("rst_data", src_data_o, 0);
        srst_i = 1'b0;
        @(negedge clk);
        check("post_rst_ready", snk_ready_o, 1);

        // Words without sop while idle are dropped.
        repeat (3) begin
            snk_valid_i = 1'b1;
            snk_data_i  = DW'($urandom);
            @(negedge clk);
        end
        snk_valid_i = 1'b0;

        fill(10);
        run_pkt(1'b1, 1'b0, 1'b1);

        fill(MAXLEN - 1);
        run_pkt(1'b0, 1'b0, 1'b1);

        pkt_q = '{8'd5, 8'd5, 8'd0, 8'd255};
        run_pkt(1'b0, 1'b1, 1'b1);

        pkt_q = '{8'h3C};
        run_pkt(1'b0, 1'b0, 1'b1);

        fill(20);
        send_pkt(1'b0, 1'b1);
        repeat (30) @(negedge clk);
        check("mid_sort_ready", snk_ready_o, 0);
        srst_i = 1'b1;
        @(negedge clk);
        check("mid_sort_rst_valid", src_valid_o, 0);
        srst_i = 1'b0;
        @(negedge clk);
        check("after_rst_ready", snk_ready_o, 1);
        vis = 0;
        repeat (20) begin
            if (src_valid_o) vis++;
            @(negedge clk);
        end
        check("after_rst_no_valid", vis, 0);

        fill(12);
        run_pkt(1'b1, 1'b1, 1'b1);

        pkt_q = '{8'd1, 8'd3, 8'd2};
        run_pkt(1'b0, 1'b0, 1'b1);

        // Repeated sop restarts the packet: only the second packet is emitted.
        fill(5);
        send_pkt(1'b0, 1'b0);
        fill(6);
        run_pkt(1'b1, 1'b0, 1'b1);

        // Length limit ends the packet without eop.
        fill(MAXLEN);
        run_pkt(1'b1, 1'b1, 1'b0);

        repeat (4) begin
            fill($urandom_range(1, MAXLEN));
            run_pkt(1'b1, 1'b1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
